// File: rtl/flash_ctrl_pkg.sv
// Shared types and JEDEC constants for the NOR flash sequencer: op codes,
// FSM state encodings, debug struct and the unlock-sequence ROM.
package flash_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_PROGRAM = 2'd2,
        OP_ERASE   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SEQ     = 3'd2,
        S_BUSYDLY = 3'd3,
        S_POLL    = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        BC_IDLE  = 2'd0,
        BC_READ  = 2'd1,
        BC_WRITE = 2'd2,
        BC_GAP   = 2'd3
    } bc_state_e;

    typedef struct packed {
        state_e    top;
        bc_state_e bus;
    } dbg_t;

    localparam logic [25:0] UNLOCK_ADDR1     = 26'h555;
    localparam logic [25:0] UNLOCK_ADDR2     = 26'h2AA;
    localparam logic [15:0] UNLOCK_DATA1     = 16'hAA;
    localparam logic [15:0] UNLOCK_DATA2     = 16'h55;
    localparam logic [15:0] CMD_PROGRAM      = 16'hA0;
    localparam logic [15:0] CMD_ERASE        = 16'h80;
    localparam logic [15:0] CMD_SECTOR_ERASE = 16'h30;

    typedef struct packed {
        logic        we;
        logic [25:0] addr;
        logic [15:0] data;
    } step_t;

    function automatic logic [2:0] seq_last(input op_e op);
        logic [2:0] last;
        last = 3'd0;
        case (op)
            OP_PROGRAM: last = 3'd3;
            OP_ERASE:   last = 3'd5;
            default:    last = 3'd0;
        endcase
        return last;
    endfunction

    // Sequence ROM: the final step of every op targets the command address.
    function automatic step_t seq_step(input op_e op, input logic [2:0] idx,
                                       input logic [25:0] addr, input logic [15:0] wdata);
        step_t s;
        s = '{we: 1'b1, addr: addr, data: wdata};
        case (op)
            OP_READ:  s = '{we: 1'b0, addr: addr, data: 16'h0000};
            OP_WRITE: s = '{we: 1'b1, addr: addr, data: wdata};
            OP_PROGRAM: begin
                case (idx)
                    3'd0:    s = '{we: 1'b1, addr: UNLOCK_ADDR1, data: UNLOCK_DATA1};
                    3'd1:    s = '{we: 1'b1, addr: UNLOCK_ADDR2, data: UNLOCK_DATA2};
                    3'd2:    s = '{we: 1'b1, addr: UNLOCK_ADDR1, data: CMD_PROGRAM};
                    default: s = '{we: 1'b1, addr: addr, data: wdata};
                endcase
            end
            OP_ERASE: begin
                case (idx)
                    3'd0:    s = '{we: 1'b1, addr: UNLOCK_ADDR1, data: UNLOCK_DATA1};
                    3'd1:    s = '{we: 1'b1, addr: UNLOCK_ADDR2, data: UNLOCK_DATA2};
                    3'd2:    s = '{we: 1'b1, addr: UNLOCK_ADDR1, data: CMD_ERASE};
                    3'd3:    s = '{we: 1'b1, addr: UNLOCK_ADDR1, data: UNLOCK_DATA1};
                    3'd4:    s = '{we: 1'b1, addr: UNLOCK_ADDR2, data: UNLOCK_DATA2};
                    default: s = '{we: 1'b1, addr: addr, data: CMD_SECTOR_ERASE};
                endcase
            end
            default: s = '{we: 1'b0, addr: addr, data: 16'h0000};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/flash_ctrl_bus.sv
// One flash bus cycle (read or write) followed by a single all-strobes-high
// gap cycle in which done pulses; a start in the gap chains the next cycle.
module flash_bus_cycle
    import flash_ctrl_pkg::*;
#(
    parameter int T_ACC = 6,
    parameter int T_SU  = 2,
    parameter int T_WP  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [25:0] addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [15:0] rdata,
    output logic [25:0] flash_a,
    output logic [15:0] flash_dq_o,
    input  logic [15:0] flash_dq_i,
    output logic        flash_dq_oe,
    output logic        flash_nce,
    output logic        flash_noe,
    output logic        flash_nwe,
    output bc_state_e   dbg_state
);

    localparam logic [7:0] ACC_LAST = 8'(T_ACC - 1);
    localparam logic [7:0] WP_FIRST = 8'(T_SU);
    localparam logic [7:0] WR_LAST  = 8'(T_SU + T_WP);

    bc_state_e   state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        load, capture;
    logic [25:0] addr_q;
    logic [15:0] wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BC_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (capture) rdata <= flash_dq_i;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        capture  = 1'b0;
        done     = 1'b0;
        case (state)
            BC_IDLE, BC_GAP: begin
                done = (state == BC_GAP);
                if (start) begin
                    load     = 1'b1;
                    cnt_nx   = '0;
                    state_nx = we ? BC_WRITE : BC_READ;
                end else begin
                    state_nx = BC_IDLE;
                end
            end
            BC_READ: begin
                if (cnt == ACC_LAST) begin
                    capture  = 1'b1;
                    state_nx = BC_GAP;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            BC_WRITE: begin
                if (cnt == WR_LAST) state_nx = BC_GAP;
                else                cnt_nx   = cnt + 8'd1;
            end
            default: state_nx = BC_IDLE;
        endcase
    end

    // Write: T_SU setup, T_WP with nWE low, then one hold cycle.
    assign flash_nce   = !((state == BC_READ) || (state == BC_WRITE));
    assign flash_noe   = (state != BC_READ);
    assign flash_nwe   = !((state == BC_WRITE) && (cnt >= WP_FIRST) && (cnt < WR_LAST));
    assign flash_dq_oe = (state == BC_WRITE);
    assign flash_a     = addr_q;
    assign flash_dq_o  = wdata_q;
    assign dbg_state   = state;

endmodule

// File: rtl/flash_ctrl.sv
// NOR flash command sequencer: READ/WRITE/PROGRAM/ERASE with JEDEC unlock
// and RY/BY# polling. Define FLASH_CTRL_TIMEOUT_EN to bound the ready poll.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int          T_ACC          = 6,
    parameter int          T_SU           = 2,
    parameter int          T_WP           = 3,
    parameter int          T_BUSY         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 240000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [25:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [25:0] flash_a,
    output logic [15:0] flash_dq_o,
    input  logic [15:0] flash_dq_i,
    output logic        flash_dq_oe,
    output logic        flash_nce,
    output logic        flash_noe,
    output logic        flash_nwe,
    input  logic        flash_ready,
    output dbg_t        dbg_state
);

    // Shared busy-delay / poll counter, sized from the timeout (28 bits by default).
    localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WAIT_W-1:0] BUSY_LAST = WAIT_W'(T_BUSY - 1);

    state_e            state, state_nx;
    op_e               op_q;
    logic [25:0]       addr_q;
    logic [15:0]       wdata_q;
    logic [2:0]        seq_idx, seq_idx_nx, rom_idx;
    logic              started, started_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [15:0]       rdata_q, rdata_nx;
    logic              rdy_s1, rdy_s2;
    logic              accept;
    logic              bc_start, bc_done;
    logic [15:0]       bc_rdata;
    bc_state_e         bc_state;
    step_t             step;

`ifdef FLASH_CTRL_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic err_q, err_nx;
`endif

    // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready
    // are both high; cmd_ready is only high in IDLE and never while rst is high.
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            seq_idx  <= '0;
            started  <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            rdy_s1   <= 1'b0;
            rdy_s2   <= 1'b0;
`ifdef FLASH_CTRL_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            seq_idx  <= seq_idx_nx;
            started  <= started_nx;
            wait_cnt <= wait_nx;
            rdata_q  <= rdata_nx;
            rdy_s1   <= flash_ready;
            rdy_s2   <= rdy_s1;
`ifdef FLASH_CTRL_TIMEOUT_EN
            err_q    <= err_nx;
`endif
            if (accept) begin
                op_q    <= op_e'(cmd_op);
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        seq_idx_nx = seq_idx;
        started_nx = started;
        wait_nx    = wait_cnt;
        rdata_nx   = rdata_q;
        rom_idx    = seq_idx;
        bc_start   = 1'b0;
`ifdef FLASH_CTRL_TIMEOUT_EN
        err_nx     = err_q;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_REQ;
                    rdata_nx = '0;
`ifdef FLASH_CTRL_TIMEOUT_EN
                    err_nx   = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_nx   = S_SEQ;
                    seq_idx_nx = '0;
                    started_nx = 1'b0;
                end
            end
            S_SEQ: begin
                if (!started) begin
                    bc_start   = 1'b1;
                    started_nx = 1'b1;
                end else if (bc_done) begin
                    if (seq_idx == seq_last(op_q)) begin
                        if (op_q == OP_READ) rdata_nx = bc_rdata;
                        if ((op_q == OP_READ) || (op_q == OP_WRITE)) begin
                            state_nx = S_DONE;
                        end else begin
                            state_nx = S_BUSYDLY;
                            wait_nx  = '0;
                        end
                    end else begin
                        // Chain the next step out of the gap cycle.
                        rom_idx    = seq_idx + 3'd1;
                        seq_idx_nx = seq_idx + 3'd1;
                        bc_start   = 1'b1;
                    end
                end
            end
            S_BUSYDLY: begin
                if (wait_cnt == BUSY_LAST) begin
                    state_nx = S_POLL;
                    wait_nx  = '0;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            S_POLL: begin
                if (rdy_s2) begin
                    state_nx = S_DONE;
                end
`ifdef FLASH_CTRL_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_LAST) begin
                    state_nx = S_DONE;
                    err_nx   = 1'b1;
                    rdata_nx = '0;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
`endif
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign step = seq_step(op_q, rom_idx, addr_q, wdata_q);

    flash_bus_cycle #(
        .T_ACC (T_ACC),
        .T_SU  (T_SU),
        .T_WP  (T_WP)
    ) u_bus (
        .clk         (clk),
        .rst         (rst),
        .start       (bc_start),
        .we          (step.we),
        .addr        (step.addr),
        .wdata       (step.data),
        .done        (bc_done),
        .rdata       (bc_rdata),
        .flash_a     (flash_a),
        .flash_dq_o  (flash_dq_o),
        .flash_dq_i  (flash_dq_i),
        .flash_dq_oe (flash_dq_oe),
        .flash_nce   (flash_nce),
        .flash_noe   (flash_noe),
        .flash_nwe   (flash_nwe),
        .dbg_state   (bc_state)
    );

    assign bus_req   = (state != S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign rsp_rdata = rsp_valid ? rdata_q : 16'h0000;
`ifdef FLASH_CTRL_TIMEOUT_EN
    assign rsp_err   = rsp_valid && err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign dbg_state = '{top: state, bus: bc_state};

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: bus-cycle and response scoreboards
// fed by expected-value queues, with a small behavioural flash model.
module tb_flash_ctrl;
    import flash_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [25:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_gnt;
    logic [25:0] flash_a;
    logic [15:0] flash_dq_o;
    logic [15:0] flash_dq_i;
    logic        flash_dq_oe;
    logic        flash_nce;
    logic        flash_noe;
    logic        flash_nwe;
    logic        flash_ready;
    dbg_t        dbg_state;

    flash_ctrl #(
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .flash_a     (flash_a),
        .flash_dq_o  (flash_dq_o),
        .flash_dq_i  (flash_dq_i),
        .flash_dq_oe (flash_dq_oe),
        .flash_nce   (flash_nce),
        .flash_noe   (flash_noe),
        .flash_nwe   (flash_nwe),
        .flash_ready (flash_ready),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- flash model ----------------
    logic [15:0] model_rdata = 16'h0000;
    assign flash_dq_i = (!flash_noe) ? model_rdata : 16'h0000;

    // ---------------- scoreboard ----------------
    logic [42:0] exp_q[$];   // {we, addr, data} per bus cycle
    logic [16:0] rsp_q[$];   // {err, rdata} per response
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [42:0] ent(input logic we, input logic [25:0] a, input logic [15:0] d);
        return {we, a, d};
    endfunction

    // ---------------- monitor ----------------
    int   acc_cyc = 0;
    int   first_fall = -1;
    int   prev_fall = -1;
    int   rsp_cyc = 0;
    int   rsp_cnt = 0;
    bit   skip_rise = 0;
    logic nce_q = 1'b1;
    logic rsp_prev = 1'b0;
    int   nce_len, noe_len, nwe_len, su_len;
    bit   nwe_seen;
    logic        cap_we;
    logic [25:0] cap_addr;
    logic [15:0] cap_data;

    always @(negedge clk) begin
        logic [42:0] e;
        logic [16:0] r;
        if (!flash_nce) begin
            if (nce_q) begin
                if (first_fall < 0) first_fall = cyc;
                else if (prev_fall >= 0) check("nce_fall_spacing", 64'(cyc - prev_fall), 64'd7);
                prev_fall = cyc;
                nce_len = 0; noe_len = 0; nwe_len = 0; su_len = 0; nwe_seen = 0;
                cap_we = flash_dq_oe; cap_addr = flash_a; cap_data = flash_dq_o;
            end
            nce_len++;
            if (!flash_noe) noe_len++;
            if (!flash_nwe) begin
                nwe_len++;
                nwe_seen = 1;
            end else if (!nwe_seen) begin
                su_len++;
            end
        end else if (!nce_q) begin
            if (skip_rise) begin
                skip_rise = 0;
            end else begin
                check("gap_noe", 64'(flash_noe), 64'd1);
                check("gap_nwe", 64'(flash_nwe), 64'd1);
                check("gap_dq_oe", 64'(flash_dq_oe), 64'd0);
                if (exp_q.size() == 0) begin
                    check("bus_cycle_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("cyc_we", 64'(cap_we), 64'(e[42]));
                    check("cyc_addr", 64'(cap_addr), 64'(e[41:16]));
                    check("cyc_nce_len", 64'(nce_len), e[42] ? 64'd6 : 64'd6);
                    if (e[42]) begin
                        check("cyc_wdata", 64'(cap_data), 64'(e[15:0]));
                        check("cyc_setup_len", 64'(su_len), 64'd2);
                        check("cyc_nwe_len", 64'(nwe_len), 64'd3);
                    end else begin
                        check("cyc_noe_len", 64'(noe_len), 64'd6);
                    end
                end
            end
        end
        nce_q = flash_nce;

        if (rsp_valid) begin
            check("rsp_pulse_width", 64'(rsp_prev), 64'd0);
            rsp_cyc = cyc;
            rsp_cnt++;
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_q.size()), 64'd1);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_err", 64'(rsp_err), 64'(r[16]));
                check("rsp_rdata", 64'(rsp_rdata), 64'(r[15:0]));
            end
        end
        rsp_prev = rsp_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [25:0] addr, input logic [15:0] data);
        bit got;
        got = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = data;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("accept_timeout", 64'(got), 64'd1);
        acc_cyc    = cyc;
        first_fall = -1;
        prev_fall  = -1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int start_cnt;
        start_cnt = rsp_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_cnt != start_cnt) return;
        end
        check("rsp_wait_timeout", 64'(rsp_cnt - start_cnt), 64'd1);
    endtask

    task automatic push_program(input logic [25:0] a, input logic [15:0] d);
        exp_q.push_back(ent(1'b1, 26'h555, 16'h00AA));
        exp_q.push_back(ent(1'b1, 26'h2AA, 16'h0055));
        exp_q.push_back(ent(1'b1, 26'h555, 16'h00A0));
        exp_q.push_back(ent(1'b1, a, d));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rdy_cyc;
        int gnt_cyc;
        int viol;
        int nwe_falls;
        logic nwe_prev;
        logic [1:0]  r_op;
        logic [25:0] r_addr;
        logic [15:0] r_data;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
        bus_gnt = 1'b1; flash_ready = 1'b1;

        // Reset, with a command presented while rst is high.
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 26'h0000042;
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        check("reset_bus_req", 64'(bus_req), 64'd0);
        check("reset_flash_a", 64'(flash_a), 64'd0);
        check("reset_dq_o", 64'(flash_dq_o), 64'd0);
        check("reset_dq_oe", 64'(flash_dq_oe), 64'd0);
        check("reset_strobes", 64'({flash_nce, flash_noe, flash_nwe}), 64'h7);
        repeat (3) @(negedge clk);
        check("rst_cmd_ignored", 64'(bus_req), 64'd0);

        // READ at 0x1234 returning BEEF.
        model_rdata = 16'hBEEF;
        exp_q.push_back(ent(1'b0, 26'h0001234, 16'h0000));
        rsp_q.push_back({1'b0, 16'hBEEF});
        issue(2'd0, 26'h0001234, 16'h0000);
        wait_rsp(100);
        check("read_first_nce_fall", 64'(first_fall - acc_cyc), 64'd3);
        check("read_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd10);

        // PROGRAM with RY/BY# low for 100 cycles.
        push_program(26'h0000100, 16'h1234);
        rsp_q.push_back({1'b0, 16'h0000});
        issue(2'd2, 26'h0000100, 16'h1234);
        flash_ready = 1'b0;
        repeat (100) @(posedge clk);
        #1 flash_ready = 1'b1;
        rdy_cyc = cyc;
        wait_rsp(200);
        check("program_rsp_after_ready", 64'(rsp_cyc - rdy_cyc), 64'd3);

        // ERASE: six writes, ready already high.
        exp_q.push_back(ent(1'b1, 26'h555, 16'h00AA));
        exp_q.push_back(ent(1'b1, 26'h2AA, 16'h0055));
        exp_q.push_back(ent(1'b1, 26'h555, 16'h0080));
        exp_q.push_back(ent(1'b1, 26'h555, 16'h00AA));
        exp_q.push_back(ent(1'b1, 26'h2AA, 16'h0055));
        exp_q.push_back(ent(1'b1, 26'h0010000, 16'h0030));
        rsp_q.push_back({1'b0, 16'h0000});
        issue(2'd3, 26'h0010000, 16'h0000);
        wait_rsp(200);
        check("erase_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd54);

        // Grant withheld for 50 cycles.
        bus_gnt = 1'b0;
        model_rdata = 16'h5A5A;
        exp_q.push_back(ent(1'b0, 26'h0002000, 16'h0000));
        rsp_q.push_back({1'b0, 16'h5A5A});
        issue(2'd0, 26'h0002000, 16'h0000);
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!flash_nce || cmd_ready || !bus_req) viol++;
        end
        check("gnt_wait_hold", 64'(viol), 64'd0);
        @(posedge clk); #1 bus_gnt = 1'b1;
        gnt_cyc = cyc;
        wait_rsp(100);
        check("gnt_to_nce_fall", 64'(first_fall - gnt_cyc), 64'd2);

        // Reset while nWE is low in the second PROGRAM write.
        exp_q.push_back(ent(1'b1, 26'h555, 16'h00AA));
        issue(2'd2, 26'h0000300, 16'hCAFE);
        nwe_falls = 0;
        nwe_prev = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!flash_nwe && nwe_prev) nwe_falls++;
            nwe_prev = flash_nwe;
            if (nwe_falls == 2) break;
        end
        check("abort_found_step2", 64'(nwe_falls), 64'd2);
        rst = 1'b1;
        skip_rise = 1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_strobes", 64'({flash_nce, flash_noe, flash_nwe}), 64'h7);
        check("abort_dq_oe", 64'(flash_dq_oe), 64'd0);
        check("abort_bus_req", 64'(bus_req), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (5) @(negedge clk);
        check("abort_exp_q_drained", 64'(exp_q.size()), 64'd0);

        model_rdata = 16'h0F0F;
        exp_q.push_back(ent(1'b0, 26'h0000777, 16'h0000));
        rsp_q.push_back({1'b0, 16'h0F0F});
        issue(2'd0, 26'h0000777, 16'h0000);
        wait_rsp(100);
        check("post_abort_read_latency", 64'(rsp_cyc - acc_cyc), 64'd10);

        // Random READ/WRITE traffic.
        for (int i = 0; i < 6; i++) begin
            r_op   = 2'($urandom_range(0, 1));
            r_addr = 26'($urandom_range(0, 32'h03FF_FFFF));
            r_data = 16'($urandom_range(0, 16'hFFFF));
            if (r_op == 2'd0) begin
                model_rdata = r_data;
                exp_q.push_back(ent(1'b0, r_addr, 16'h0000));
                rsp_q.push_back({1'b0, r_data});
            end else begin
                exp_q.push_back(ent(1'b1, r_addr, r_data));
                rsp_q.push_back({1'b0, 16'h0000});
            end
            issue(r_op, r_addr, r_data);
            wait_rsp(100);
            check("rand_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd10);
        end

`ifdef FLASH_CTRL_TIMEOUT_EN
        // Ready stuck low: poll gives up after 1000 cycles in POLL.
        push_program(26'h0000500, 16'h4321);
        rsp_q.push_back({1'b1, 16'h0000});
        issue(2'd2, 26'h0000500, 16'h4321);
        flash_ready = 1'b0;
        wait_rsp(1200);
        check("timeout_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd1039);
        flash_ready = 1'b1;
`endif

        repeat (5) @(negedge clk);
        check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("final_rsp_q_empty", 64'(rsp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
